// File: rtl/slice_eval_pkg.sv
// slice_eval_pkg
//   Shared definitions for the bit-serial slice evaluator:
//   - state_t     : controller states IDLE / RUN / DONE
//   - WIDTH_DEF   : default number of bit slices per operand word
package slice_eval_pkg;

   localparam int WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/slice_cell.sv
// slice_cell
//   One bit slice of the evaluator: a fixed eight-gate network.
//   Ports:
//     a_bit  in   operand A bit
//     b_bit  in   operand B bit
//     y_bit  out  slice result (reduces to b_bit)
module slice_cell (
   input  logic a_bit,
   input  logic b_bit,
   output logic y_bit
);

   logic w0, w1, w2, w3, w4, w5, w6;

   assign w0    = a_bit & b_bit;
   assign w1    = a_bit | b_bit;
   assign w2    = a_bit | w0;
   assign w3    = b_bit & w1;
   assign w4    = w0 ^ w1;
   assign w5    = ~(w2 & w4);
   assign w6    = ~(w3 | w4);
   assign y_bit = w5 ^ w6;

endmodule

// File: rtl/slice_serial_eval.sv
// slice_serial_eval
//   Captures an operand word pair, evaluates one bit slice per clock from
//   MSB down to bit 0 through a single slice_cell, then presents the result
//   word until the consumer takes it.
//   Ports:
//     clk        in   clock, rising edge
//     rst        in   asynchronous active-high reset
//     in_valid   in   operand word a/b presented
//     in_ready   out  block can accept an operand word (IDLE only)
//     a, b       in   operand words [WIDTH]
//     out_valid  out  result y presented (DONE only)
//     out_ready  in   consumer accepts y
//     y          out  result word [WIDTH], zero outside DONE
//     busy       out  high in any state other than IDLE
module slice_serial_eval
   import slice_eval_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_r, b_r, res_r;
   logic             a_bit, b_bit, y_bit;
   logic             accept;

   // Counter-selected operand bits; a compare-mux avoids out-of-range
   // indexing when WIDTH is not a power of two.
   always_comb begin
      a_bit = 1'b0;
      b_bit = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (cnt == CW'(i)) begin
            a_bit = a_r[i];
            b_bit = b_r[i];
         end
      end
   end

   slice_cell u_cell (
      .a_bit (a_bit),
      .b_bit (b_bit),
      .y_bit (y_bit)
   );

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            if (cnt == '0) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign accept = in_valid & in_ready;
   assign y      = (state == DONE) ? res_r : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         a_r   <= '0;
         b_r   <= '0;
         res_r <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            a_r   <= a;
            b_r   <= b;
            res_r <= '0;
            cnt   <= CW'(WIDTH - 1);
         end else if (state == RUN) begin
            for (int i = 0; i < WIDTH; i++) begin
               if (cnt == CW'(i)) res_r[i] <= y_bit;
            end
            if (cnt != '0) cnt <= cnt - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_slice_serial_eval.sv
module tb_slice_serial_eval;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready, out_valid, out_ready, busy;
   logic [3:0] a, b, y;
   // WIDTH=1 instance
   logic       iv1, ir1, ov1, or1, busy1;
   logic [0:0] a1, b1, y1;

   int vecs = 0;
   int miss = 0;
   logic [3:0] sb[$];

   always #5 clk = ~clk;

   slice_serial_eval #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .busy(busy)
   );

   slice_serial_eval #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
      .a(a1), .b(b1), .out_valid(ov1), .out_ready(or1),
      .y(y1), .busy(busy1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Starts and ends at a negedge. Drives one word, scrambles a/b/in_valid
   // during RUN, optionally stalls the consumer for 'hold' cycles.
   task automatic xfer(input logic [3:0] ta, input logic [3:0] tb, input int hold);
      int w, lat;
      logic [3:0] e;
      w = 0;
      while (!in_ready && w < 20) begin @(negedge clk); w++; end
      chk("in_ready_idle", in_ready, 1);
      a = ta; b = tb; in_valid = 1'b1; out_ready = (hold == 0);
      sb.push_back(tb);
      lat = 0;
      do begin
         @(negedge clk); lat++;
         if (!out_valid) begin
            chk("in_ready_run", in_ready, 0);
            chk("busy_run", busy, 1);
            chk("y_zero_run", y, 0);
         end
         a = 4'($urandom); b = 4'($urandom); in_valid = 1'($urandom);
      end while (!out_valid && lat < 30);
      in_valid = 1'b0;
      chk("latency", lat, 5);
      for (int i = 0; i < hold; i++) begin
         chk("hold_valid", out_valid, 1);
         chk("hold_y", y, tb);
         chk("in_ready_done", in_ready, 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      chk("out_valid", out_valid, 1);
      chk("in_ready_done", in_ready, 0);
      chk("busy_done", busy, 1);
      if (sb.size() == 0) chk("sb_empty", 1, 0);
      else begin
         e = sb.pop_front();
         chk("y", y, e);
      end
      @(negedge clk);
      chk("idle_valid", out_valid, 0);
      chk("idle_ready", in_ready, 1);
      chk("idle_y", y, 0);
      chk("idle_busy", busy, 0);
   endtask

   initial begin
      int lat;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
      iv1 = 1'b0; or1 = 1'b1; a1 = '0; b1 = '0;
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_y", y, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      // basic word
      xfer(4'b1010, 4'b0110, 0);

      // all pairs back-to-back
      for (int i = 0; i < 256; i++) xfer(4'(i >> 4), 4'(i), 0);

      // consumer stall
      xfer(4'hF, 4'h3, 10);

      // operand scramble during RUN
      xfer(4'h2, 4'hC, 0);

      // reset mid-RUN
      a = 4'h0; b = 4'hF; in_valid = 1'b1;
      @(negedge clk);           // first RUN cycle
      in_valid = 1'b0; a = 4'hA; b = 4'h5;
      @(negedge clk);           // second RUN cycle
      chk("pre_rst_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("abort_in_ready", in_ready, 1);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_y", y, 0);
      chk("abort_busy", busy, 0);
      @(negedge clk);
      chk("abort_hold_valid", out_valid, 0);
      chk("abort_hold_ready", in_ready, 1);
      rst = 1'b0;
      xfer(4'h5, 4'h9, 0);
      chk("sb_drained", sb.size(), 0);

      // WIDTH=1 instance
      a1 = 1'b0; b1 = 1'b1; iv1 = 1'b1;
      lat = 0;
      do begin
         @(negedge clk); lat++;
         iv1 = 1'b0;
      end while (!ov1 && lat < 10);
      chk("w1_latency", lat, 2);
      chk("w1_y", y1, 1);
      @(negedge clk);
      chk("w1_idle_valid", ov1, 0);
      chk("w1_idle_ready", ir1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
